// File: rtl/image_matrix_engine_pkg.sv
// Shared types and sizing helpers for the image matrix engine.
package img_pkg;

  // Default geometry: 3x3 matrix of 3-bit pixels.
  localparam int N_DEF      = 3;
  localparam int DATA_W_DEF = 3;

  // Command codes carried on the mode bus.
  typedef enum logic [2:0] {
    MODE_OUTPUT    = 3'd0,
    MODE_FLIP_H    = 3'd1,
    MODE_FLIP_V    = 3'd2,
    MODE_ROT_CW    = 3'd3,
    MODE_ROT_CCW   = 3'd4,
    MODE_COL_INC   = 3'd5,
    MODE_TRANSPOSE = 3'd6,
    MODE_LOAD      = 3'd7
  } mode_e;

  // Engine control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Number of pixels held for an n x n matrix.
  function automatic int npix(input int n);
    return n * n;
  endfunction

  // Width of the row-major pixel index counter.
  function automatic int idxWidth(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  // Width of the column selector.
  function automatic int colWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_matrix_engine_if.sv
// Command/pixel bus between the pixel source and the matrix engine.
interface image_matrix_engine_if
  import img_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int COL_W = colWidth(N);

  logic              in_valid;
  logic [2:0]        mode;
  logic [COL_W-1:0]  col_sel;
  logic [DATA_W-1:0] in;
  logic              ready;
  logic              out_valid;
  logic [DATA_W-1:0] out;

  // Source side drives commands and pixels.
  modport master (
    output in_valid, mode, col_sel, in,
    input  ready, out_valid, out
  );

  // Engine side.
  modport slave (
    input  in_valid, mode, col_sel, in,
    output ready, out_valid, out
  );
endinterface

// File: rtl/image_matrix_engine_sat_inc.sv
// Combinational pixel increment that sticks at full scale instead of wrapping.
module sat_inc #(
  parameter int DATA_W = 3
) (
  input  logic [DATA_W-1:0] pix_i,
  output logic [DATA_W-1:0] pix_o
);

  // All-ones input is already saturated, anything else steps by one.
  assign pix_o = (&pix_i) ? pix_i : pix_i + DATA_W'(1);

endmodule

// File: rtl/image_matrix_engine.sv
// N x N pixel matrix engine: serial load, in-place geometric and saturating
// column ops completing in one cycle, and a serial row-major readout.
module image_matrix_engine
  import img_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  image_matrix_engine_if.slave bus
);

  localparam int NPIX  = npix(N);
  localparam int IDX_W = idxWidth(N);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              ready_q;
  logic              outValid_q;
  logic [DATA_W-1:0] outData_q;
  logic [DATA_W-1:0] pix_q  [NPIX];
  logic [DATA_W-1:0] pix_d  [NPIX];

  logic [DATA_W-1:0] flipH  [NPIX];
  logic [DATA_W-1:0] flipV  [NPIX];
  logic [DATA_W-1:0] rotCw  [NPIX];
  logic [DATA_W-1:0] rotCcw [NPIX];
  logic [DATA_W-1:0] transp [NPIX];
  logic [DATA_W-1:0] colInc [NPIX];
  logic [DATA_W-1:0] colPix [N];
  logic [DATA_W-1:0] incPix [N];

  // Every op result is a fixed rewiring of the current matrix, except the
  // column increment which swaps in the saturated pixel of the selected column.
  for (genvar r = 0; r < N; r++) begin : gRow
    for (genvar c = 0; c < N; c++) begin : gCol
      assign flipH[r*N+c]  = pix_q[r*N + (N-1-c)];
      assign flipV[r*N+c]  = pix_q[(N-1-r)*N + c];
      assign rotCw[r*N+c]  = pix_q[(N-1-c)*N + r];
      assign rotCcw[r*N+c] = pix_q[c*N + (N-1-r)];
      assign transp[r*N+c] = pix_q[c*N + r];
      assign colInc[r*N+c] = (int'(bus.col_sel) == c) ? incPix[r] : pix_q[r*N+c];
    end

    // Pick this row's pixel in the selected column; out-of-range selects nothing.
    always_comb begin
      colPix[r] = '0;
      for (int c = 0; c < N; c++) begin
        if (int'(bus.col_sel) == c) colPix[r] = pix_q[IDX_W'(r*N + c)];
      end
    end

    sat_inc #(.DATA_W(DATA_W)) uInc (
      .pix_i (colPix[r]),
      .pix_o (incPix[r])
    );
  end

  // Choose the rewritten matrix for the op currently on the mode bus.
  always_comb begin
    pix_d = pix_q;
    case (mode_e'(bus.mode))
      MODE_FLIP_H:    pix_d = flipH;
      MODE_FLIP_V:    pix_d = flipV;
      MODE_ROT_CW:    pix_d = rotCw;
      MODE_ROT_CCW:   pix_d = rotCcw;
      MODE_COL_INC:   pix_d = colInc;
      MODE_TRANSPOSE: pix_d = transp;
      default:        pix_d = pix_q;
    endcase
  end

  // Control FSM with registered handshake and readout outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      pix_q      <= '{default: '0};
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q    <= 1'b1;
          outValid_q <= 1'b0;
          outData_q  <= '0;
          if (bus.in_valid && ready_q) begin
            case (mode_e'(bus.mode))
              MODE_LOAD: begin
                pix_q[0] <= bus.in;
                idx_q    <= IDX_W'(1);
                ready_q  <= 1'b0;
                state_q  <= ST_LOAD;
              end
              MODE_OUTPUT: begin
                idx_q      <= '0;
                ready_q    <= 1'b0;
                outValid_q <= 1'b1;
                outData_q  <= pix_q[0];
                state_q    <= ST_OUT;
              end
              default: pix_q <= pix_d;
            endcase
          end
        end
        ST_LOAD: begin
          if (bus.in_valid) begin
            pix_q[idx_q] <= bus.in;
            if (idx_q == IDX_W'(NPIX-1)) begin
              idx_q   <= '0;
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_OUT: begin
          if (idx_q == IDX_W'(NPIX-1)) begin
            idx_q      <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            ready_q    <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            idx_q     <= idx_q + IDX_W'(1);
            outData_q <= pix_q[idx_q + IDX_W'(1)];
          end
        end
        default: begin
          idx_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.out_valid = outValid_q;
  assign bus.out       = outData_q;

endmodule
